// File: rtl/trap_sequencer.sv
// Trap/return sequencer: saves mepc/mcause through a single-port CSR request channel, fetches
// the new PC (mtvec or mepc), flushes the pipeline and emits a one-cycle redirect.
module trap_sequencer #(
  parameter logic [11:0] MTVEC_ADDR  = 12'h305,
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic [1:0]  trap_kind,
  input  logic [31:0] trap_pc,
  output logic        trap_ready,
  output logic        csr_req_valid,
  input  logic        csr_req_ready,
  output logic        csr_req_we,
  output logic [11:0] csr_req_addr,
  output logic [31:0] csr_req_wdata,
  input  logic        csr_rsp_valid,
  input  logic [31:0] csr_rsp_rdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] trap_count
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] W_EPC     = 3'd1;
  localparam logic [2:0] W_CAUSE   = 3'd2;
  localparam logic [2:0] R_TVEC    = 3'd3;
  localparam logic [2:0] WAIT_TVEC = 3'd4;
  localparam logic [2:0] R_EPC     = 3'd5;
  localparam logic [2:0] WAIT_EPC  = 3'd6;
  localparam logic [2:0] REDIRECT  = 3'd7;

  localparam logic [1:0] KindEcall = 2'd0;
  localparam logic [1:0] KindMret  = 2'd2;

  logic [2:0]  state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] trap_count_q, trap_count_d;
  logic        csr_xfer;

  always_comb begin
    trap_ready     = (state_q == IDLE) && !rst;
    flush          = (state_q != IDLE) && !rst;
    redirect_valid = (state_q == REDIRECT) && !rst;
    csr_req_valid  = !rst && ((state_q == W_EPC) || (state_q == W_CAUSE) ||
                              (state_q == R_TVEC) || (state_q == R_EPC));
  end

  // Request fields are pure functions of state and latched data, so they stay stable under stall.
  always_comb begin
    csr_req_we    = 1'b0;
    csr_req_addr  = '0;
    csr_req_wdata = '0;
    case (state_q)
      W_EPC: begin
        csr_req_we    = 1'b1;
        csr_req_addr  = MEPC_ADDR;
        csr_req_wdata = pc_q;
      end
      W_CAUSE: begin
        csr_req_we    = 1'b1;
        csr_req_addr  = MCAUSE_ADDR;
        csr_req_wdata = (kind_q == KindEcall) ? 32'd11 : 32'd2;
      end
      R_TVEC:  csr_req_addr = MTVEC_ADDR;
      R_EPC:   csr_req_addr = MEPC_ADDR;
      default: ;
    endcase
  end

  assign csr_xfer    = csr_req_valid && csr_req_ready;
  assign redirect_pc = (state_q == REDIRECT) ? target_q : redirect_pc_q;
  assign trap_count  = trap_count_q;

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    pc_d          = pc_q;
    target_d      = target_q;
    redirect_pc_d = redirect_pc_q;
    trap_count_d  = trap_count_q;
    case (state_q)
      IDLE: begin
        if (trap_valid && trap_ready) begin
          kind_d  = trap_kind;
          pc_d    = trap_pc;
          state_d = (trap_kind == KindMret) ? R_EPC : W_EPC;
        end
      end
      W_EPC:   if (csr_xfer) state_d = W_CAUSE;
      W_CAUSE: if (csr_xfer) state_d = R_TVEC;
      R_TVEC:  if (csr_xfer) state_d = WAIT_TVEC;
      R_EPC:   if (csr_xfer) state_d = WAIT_EPC;
      WAIT_TVEC, WAIT_EPC: begin
        if (csr_rsp_valid) begin
          target_d = csr_rsp_rdata & ~32'h3;
          state_d  = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_pc_d = target_q;
        trap_count_d  = trap_count_q + 32'd1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      kind_q        <= '0;
      pc_q          <= '0;
      target_q      <= '0;
      redirect_pc_q <= '0;
      trap_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      pc_q          <= pc_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
      trap_count_q  <= trap_count_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus randomized traps, each checked against an
// expected CSR transaction list and redirect target built from the trap kind and CSR data.
module tb_trap_sequencer;

  localparam logic [11:0] MTVEC  = 12'h305;
  localparam logic [11:0] MEPC   = 12'h341;
  localparam logic [11:0] MCAUSE = 12'h342;

  logic        clk;
  logic        rst;
  logic        trap_valid;
  logic [1:0]  trap_kind;
  logic [31:0] trap_pc;
  logic        trap_ready;
  logic        csr_req_valid;
  logic        csr_req_ready;
  logic        csr_req_we;
  logic [11:0] csr_req_addr;
  logic [31:0] csr_req_wdata;
  logic        csr_rsp_valid;
  logic [31:0] csr_rsp_rdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] trap_count;

  int          n_cmp;
  int          n_err;
  logic [31:0] model_count;
  logic [31:0] model_pc;

  trap_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .trap_valid     (trap_valid),
    .trap_kind      (trap_kind),
    .trap_pc        (trap_pc),
    .trap_ready     (trap_ready),
    .csr_req_valid  (csr_req_valid),
    .csr_req_ready  (csr_req_ready),
    .csr_req_we     (csr_req_we),
    .csr_req_addr   (csr_req_addr),
    .csr_req_wdata  (csr_req_wdata),
    .csr_rsp_valid  (csr_rsp_valid),
    .csr_rsp_rdata  (csr_rsp_rdata),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_count     (trap_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and acts as the CSR slave until the redirect; called at a negedge.
  task automatic run_trap(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] rdata,
                          input int stall_pct, input int cause_stall, input int rsp_dly,
                          input bit hold, input bit spur, input bit chk_lat);
    logic [44:0] exp_q[$];
    logic [44:0] got_q[$];
    logic [44:0] cur;
    logic [44:0] held;
    logic [31:0] exp_pc;
    int          w, edges, rsp_cnt, cstall;
    bit          stalled, done, read_sent;
    w = 0; edges = 0; rsp_cnt = -1; cstall = cause_stall;
    stalled = 0; done = 0; read_sent = 0; held = '0;
    while (!trap_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", trap_ready, 1);
    if (kind == 2'd2) begin
      exp_q.push_back({1'b0, MEPC, 32'h0});
    end else begin
      exp_q.push_back({1'b1, MEPC, pc});
      exp_q.push_back({1'b1, MCAUSE, (kind == 2'd0) ? 32'd11 : 32'd2});
      exp_q.push_back({1'b0, MTVEC, 32'h0});
    end
    exp_pc     = rdata & 32'hFFFF_FFFC;
    trap_valid = 1'b1;
    trap_kind  = kind;
    trap_pc    = pc;
    while (!done && edges < 200) begin
      @(negedge clk);
      edges++;
      trap_valid    = hold;
      csr_rsp_valid = 1'b0;
      csr_rsp_rdata = '0;
      if (rsp_cnt == 0) begin
        csr_rsp_valid = 1'b1;
        csr_rsp_rdata = rdata;
      end else if (spur && !read_sent && $urandom_range(0, 3) == 0) begin
        csr_rsp_valid = 1'b1;
        csr_rsp_rdata = 32'hDEAD_BEE0;
      end
      if (rsp_cnt >= 0) rsp_cnt--;
      if (redirect_valid) begin
        done = 1;
        chk("redirect_pc", redirect_pc, exp_pc);
        chk("flush_redirect", flush, 1);
        chk("no_accept_in_redirect", trap_ready, 0);
        chk("no_req_in_redirect", csr_req_valid, 0);
      end else begin
        chk("flush_busy", flush, 1);
        if (csr_req_valid) begin
          cur = {csr_req_we, csr_req_addr, csr_req_wdata};
          if (stalled) chk("csr_stable", cur, held);
          if (cstall > 0 && csr_req_addr == MCAUSE) begin
            csr_req_ready = 1'b0;
            cstall--;
          end else begin
            csr_req_ready = ($urandom_range(0, 99) >= stall_pct);
          end
          stalled = !csr_req_ready;
          held    = cur;
          if (csr_req_ready) begin
            got_q.push_back(cur);
            if (!cur[44]) begin
              read_sent = 1;
              rsp_cnt   = rsp_dly;
            end
          end
        end else begin
          csr_req_ready = ($urandom_range(0, 1) != 0);
          stalled       = 0;
        end
      end
    end
    chk("redirect_seen", done, 1);
    if (chk_lat) chk("latency", edges, (kind == 2'd2) ? 3 : 5);
    chk("xfer_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("xfer", got_q[i], exp_q[i]);
    model_count = model_count + 32'd1;
    model_pc    = exp_pc;
    @(negedge clk);
    csr_rsp_valid = 1'b0;
    csr_req_ready = 1'b1;
    chk("redirect_one_cycle", redirect_valid, 0);
    chk("redirect_pc_hold", redirect_pc, model_pc);
    chk("trap_count", trap_count, model_count);
    chk("ready_after", trap_ready, 1);
    chk("flush_idle", flush, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; model_count = '0; model_pc = '0;
    rst = 1'b1; trap_valid = 1'b0; trap_kind = '0; trap_pc = '0;
    csr_req_ready = 1'b1; csr_rsp_valid = 1'b0; csr_rsp_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_trap_ready", trap_ready, 0);
    chk("rst_csr_valid", csr_req_valid, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_count", trap_count, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", trap_ready, 1);

    // ecall and mret at minimum latency
    run_trap(2'd0, 32'h100, 32'h200, 0, 0, 0, 0, 0, 1);
    run_trap(2'd2, 32'h0, 32'h104, 0, 0, 0, 0, 0, 1);
    // mcause write stalled for three cycles
    run_trap(2'd3, 32'h180, 32'h240, 0, 3, 0, 0, 0, 0);
    // illegal instruction, mtvec low bits masked, request held across the redirect
    run_trap(2'd1, 32'h500, 32'h203, 0, 0, 0, 1, 0, 0);
    run_trap(2'd1, 32'h500, 32'h600, 0, 0, 1, 0, 0, 0);

    // reset while waiting for the mtvec response, then a late response
    trap_valid = 1'b1; trap_kind = 2'd0; trap_pc = 32'h300; csr_req_ready = 1'b1;
    repeat (4) @(negedge clk);
    trap_valid = 1'b0;
    chk("mid_wait_flush", flush, 1);
    chk("mid_wait_noreq", csr_req_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", trap_ready, 0);
    chk("mid_rst_flush", flush, 0);
    rst = 1'b0; csr_rsp_valid = 1'b1; csr_rsp_rdata = 32'h400;
    model_count = '0; model_pc = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      csr_rsp_valid = 1'b0;
      chk("late_rsp_no_redirect", redirect_valid, 0);
    end
    chk("late_rsp_count", trap_count, model_count);
    chk("late_rsp_ready", trap_ready, 1);
    chk("late_rsp_pc", redirect_pc, model_pc);

    // randomized traps with stalls, delayed and spurious responses
    for (int t = 0; t < 20; t++) begin
      run_trap(2'($urandom_range(0, 3)), $urandom, $urandom, 30, 0,
               int'($urandom_range(0, 3)), 0, 1, 0);
    end

    // counter wrap
    force dut.trap_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.trap_count_q;
    model_count = 32'hFFFF_FFFF;
    chk("count_preset", trap_count, model_count);
    run_trap(2'd0, 32'h700, 32'h800, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Parameters
REQ-001 SHALL provide parameter MTVEC_ADDR, default 12'h305, CSR address read for the trap vector.
REQ-002 SHALL provide parameter MEPC_ADDR, default 12'h341, CSR address for the exception PC.
REQ-003 SHALL provide parameter MCAUSE_ADDR, default 12'h342, CSR address for the trap cause.

Interface
REQ-004 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: trap_valid  in  1  pipeline requests a trap/return.
REQ-007 SHALL have port: trap_kind  in  2  0=ecall, 1=illegal instruction, 2=mret, 3=reserved.
REQ-008 SHALL have port: trap_pc  in  32  PC of the trapping instruction.
REQ-009 SHALL have port: trap_ready  out  1  sequencer can accept a request.
REQ-010 SHALL have ports: csr_req_valid out 1; csr_req_ready in 1; csr_req_we out 1 (1=write); csr_req_addr out 12; csr_req_wdata out 32.
REQ-011 SHALL have ports: csr_rsp_valid in 1; csr_rsp_rdata in 32 (read data, returned for reads only).
REQ-012 SHALL have ports: flush out 1 (pipeline kill); redirect_valid out 1; redirect_pc out 32; trap_count out 32.

Function
REQ-013 SHALL use FSM states IDLE, W_EPC, W_CAUSE, R_TVEC, WAIT_TVEC, R_EPC, WAIT_EPC, REDIRECT.
REQ-014 SHALL drive trap_ready=1 only in IDLE; request accepted when trap_valid & trap_ready on a clock edge, latching trap_kind and trap_pc.
REQ-015 SHALL on accept go IDLE->W_EPC for kinds 0,1,3 and IDLE->R_EPC for kind 2.
REQ-016 SHALL in W_EPC issue write addr=MEPC_ADDR, wdata=latched pc; on transfer go W_CAUSE.
REQ-017 SHALL in W_CAUSE issue write addr=MCAUSE_ADDR, wdata=11 (kind 0) or 2 (kinds 1,3); on transfer go R_TVEC.
REQ-018 SHALL in R_TVEC issue read addr=MTVEC_ADDR; on transfer go WAIT_TVEC; on csr_rsp_valid latch target = rdata & ~32'h3, go REDIRECT.
REQ-019 SHALL in R_EPC issue read addr=MEPC_ADDR; on transfer go WAIT_EPC; on csr_rsp_valid latch target = rdata & ~32'h3, go REDIRECT.
REQ-020 SHALL count a CSR transfer only when csr_req_valid & csr_req_ready; valid, we, addr, wdata held stable while valid & !ready.
REQ-021 SHALL assert csr_req_valid only in W_EPC, W_CAUSE, R_TVEC, R_EPC; csr_req_we=1 only in W_EPC/W_CAUSE; wdata=0 on reads.
REQ-022 SHALL keep at most one read outstanding; response accepted no earlier than the cycle after the read transfer.
REQ-023 SHALL ignore csr_rsp_valid in any state other than WAIT_TVEC/WAIT_EPC.
REQ-024 SHALL in REDIRECT drive redirect_valid=1 for exactly one cycle with redirect_pc=target, increment trap_count (mod 2^32), go IDLE.
REQ-025 SHALL hold redirect_pc at last target when redirect_valid=0.
REQ-026 SHALL drive flush=1 in every state except IDLE (REDIRECT cycle inclusive).
REQ-027 SHALL not accept a new request in the REDIRECT cycle; earliest next accept is the cycle after redirect_valid.
REQ-028 SHALL have minimum latency accept->redirect_valid of 5 cycles (trap) / 3 cycles (mret) with csr_req_ready=1 and 1-cycle response.

Reset
REQ-029 SHALL on rst=1 enter IDLE and clear trap_count, redirect_pc, target, latched kind/pc to 0; csr_req_valid, redirect_valid, flush = 0; trap_ready = 0 while rst=1.
REQ-030 SHALL on reset mid-sequence abandon it with no redirect; a late response after reset is ignored per REQ-023.

Verification
REQ-031 ecall: pc=0x100, kind=0, mtvec returns 0x200 -> writes (0x341,0x100), (0x342,11), read 0x305, redirect_pc=0x200, trap_count=1.
REQ-032 mret: kind=2, mepc read returns 0x104 -> single read of 0x341, no writes, redirect_pc=0x104.
REQ-033 backpressure: csr_req_ready low 3 cycles during W_CAUSE -> addr 0x342/wdata 2 stable, flush held, no duplicate write.
REQ-034 illegal with mtvec=0x203 -> mcause=2, redirect_pc=0x200; trap_valid held through REDIRECT not accepted until next cycle.
REQ-035 rst asserted in WAIT_TVEC, then response arrives -> no redirect_valid, trap_count=0, trap_ready=1 after rst drops.
REQ-036 trap_count at 0xFFFFFFFF plus one trap -> wraps to 0.
